// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is reused LSB-first over WIDTH cycles.
// Optional subtract mode is compiled in with SERIAL_ADDER_SUB_EN.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] res_sr_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH-1:0] b_load;
   logic             carry_load;
   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] res_next;

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: invert B and force a carry-in of one.
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub | cin;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign b_load     = b;
   assign carry_load = cin;
`endif

   full_adder u_fa (
      .a  (a_sr_q[0]),
      .b  (b_sr_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign res_next = {fa_s, res_sr_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b_load;
                  carry_q <= carry_load;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               a_sr_q   <= a_sr_q >> 1;
               b_sr_q   <= b_sr_q >> 1;
               res_sr_q <= res_next;
               carry_q  <= fa_co;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  sum     <= res_next;
                  cout    <= fa_co;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               done    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8); expected results queue up at
// issue and are popped when done pulses.

module tb_serial_adder_ctrl;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int tests_run;
   int tests_failed;

   logic [WIDTH:0] sb_q[$];

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                            input logic vc, input logic vs);
      logic [WIDTH:0] r;
      r = {1'b0, va} + {1'b0, vb} + {{WIDTH{1'b0}}, vc};
`ifdef SERIAL_ADDER_SUB_EN
      if (vs) r = {1'b0, va} + {1'b0, ~vb} + {{WIDTH{1'b0}}, 1'b1};
`else
      if (vs) r = r; // subtract is not built in: plain add
`endif
      return r;
   endfunction

   // Issue one op; returns at the negedge just after the accepting edge.
   task automatic drive_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input logic vc, input logic vs);
      @(negedge clk);
      a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
      sb_q.push_back(model(va, vb, vc, vs));
      @(negedge clk);
      start = 1'b0;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
   endtask

   // Bounded wait for done, sampled on negedges.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; a = '1; b = '1; cin = 1'b1; sub = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({busy, done, cout, sum} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0",
                  busy, done, cout, sum);
      end
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_latency();
      logic [WIDTH:0] exp;
      int             bad;
      drive_op(8'h5A, 8'h3C, 1'b0, 1'b0);
      bad = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) bad++;
         @(negedge clk);
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL latency_busy: got %0d bad cycles of busy=1/done=0, want 0", bad);
      end
      exp = sb_q.pop_front();
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0 || {cout, sum} !== exp) begin
         tests_failed++;
         $display("FAIL latency_done: got done=%b busy=%b cout=%b sum=%h, want 1 0 %b %h",
                  done, busy, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || {cout, sum} !== exp) begin
         tests_failed++;
         $display("FAIL done_pulse: got done=%b cout=%b sum=%h, want 0 %b %h",
                  done, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
      end
   endtask

   task automatic test_add();
      logic [WIDTH-1:0] ta[4] = '{8'hFF, 8'hFF, 8'h00, 8'hA7};
      logic [WIDTH-1:0] tb[4] = '{8'h01, 8'h00, 8'h00, 8'h6B};
      logic             tc[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [WIDTH:0]   exp;
      int               cyc;
      for (int i = 0; i < 4; i++) begin
         drive_op(ta[i], tb[i], tc[i], 1'b0);
         wait_done(cyc);
         exp = sb_q.pop_front();
         tests_run++;
         if (cyc != WIDTH || {cout, sum} !== exp) begin
            tests_failed++;
            $display("FAIL add_%0d: got cyc=%0d cout=%b sum=%h, want cyc=%0d cout=%b sum=%h",
                     i, cyc, cout, sum, WIDTH, exp[WIDTH], exp[WIDTH-1:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] va[3] = '{8'h01, 8'h80, 8'h33};
      logic [WIDTH-1:0] vb[3] = '{8'h02, 8'h90, 8'h44};
      logic [WIDTH:0]   exp;
      logic [WIDTH:0]   prev;
      int               cyc;
      prev = {cout, sum};
      @(negedge clk);
      start = 1'b1;
      for (int j = 0; j < 3; j++) begin
         a = va[j]; b = vb[j]; cin = 1'b0; sub = 1'b0;
         sb_q.push_back(model(va[j], vb[j], 1'b0, 1'b0));
         @(negedge clk);
         tests_run++;
         if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_accept_%0d: got busy=%b, want 1", j, busy);
         end
         a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
         @(negedge clk);
         if (j > 0) begin
            tests_run++;
            if ({cout, sum} !== prev) begin
               tests_failed++;
               $display("FAIL b2b_hold_%0d: got %h, want %h", j, {cout, sum}, prev);
            end
         end
         wait_done(cyc);
         exp = sb_q.pop_front();
         tests_run++;
         if (cyc != WIDTH - 1 || {cout, sum} !== exp) begin
            tests_failed++;
            $display("FAIL b2b_result_%0d: got cyc=%0d res=%h, want cyc=%0d res=%h",
                     j, cyc + 1, {cout, sum}, WIDTH, exp);
         end
         prev = exp;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [WIDTH:0] exp;
      int             cyc;
      drive_op(8'h12, 8'h34, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, cout, sum} !== '0) begin
         tests_failed++;
         $display("FAIL async_reset: got busy=%b done=%b cout=%b sum=%h, want all 0",
                  busy, done, cout, sum);
      end
      void'(sb_q.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      drive_op(8'h01, 8'h01, 1'b0, 1'b0);
      wait_done(cyc);
      exp = sb_q.pop_front();
      tests_run++;
      if (cyc != WIDTH || {cout, sum} !== exp) begin
         tests_failed++;
         $display("FAIL post_reset_op: got cyc=%0d cout=%b sum=%h, want cyc=%0d cout=%b sum=%h",
                  cyc, cout, sum, WIDTH, exp[WIDTH], exp[WIDTH-1:0]);
      end
   endtask

   task automatic test_sub();
      logic [WIDTH-1:0] ta[3] = '{8'h10, 8'h00, 8'h10};
      logic [WIDTH-1:0] tb[3] = '{8'h01, 8'h01, 8'h01};
      logic             tc[3] = '{1'b0, 1'b0, 1'b1};
      logic             ts[3] = '{1'b1, 1'b1, 1'b0};
      logic [WIDTH:0]   exp;
      int               cyc;
      for (int i = 0; i < 3; i++) begin
         drive_op(ta[i], tb[i], tc[i], ts[i]);
         wait_done(cyc);
         exp = sb_q.pop_front();
         tests_run++;
         if (cyc != WIDTH || {cout, sum} !== exp) begin
            tests_failed++;
            $display("FAIL sub_%0d: got cyc=%0d cout=%b sum=%h, want cyc=%0d cout=%b sum=%h",
                     i, cyc, cout, sum, WIDTH, exp[WIDTH], exp[WIDTH-1:0]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by time limit, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_latency();
      test_add();
      test_back_to_back();
      test_async_reset();
      test_sub();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that sequences one 1-bit `FullAdder` cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first. It holds the carry in a flip-flop between bit steps and presents a registered result with a start/busy/done handshake. It sits between a requesting datapath and the shared adder cell, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- Cin  input  1  carry-in; captured on the accepting edge.
- Sub  input  1  subtract mode, captured on the accepting edge; effect depends on configuration.
- Busy  output  1  high while an operation is in progress (RUN).
- Done  output  1  one-cycle pulse when Sum/Cout become valid.
- Sum  output  WIDTH  registered result; holds until the next completion.
- Cout  output  1  registered final carry; holds until the next completion.

## Operation
- State machine states: IDLE, RUN, DONE. Encoding is implementer's choice.
- IDLE:
  - Start=1 at an edge loads the A and B shift registers, carry FF ← Cin, and bit counter ← 0, then moves to RUN.
  - Start=0 stays in IDLE.
- RUN:
  - Each edge applies a_sr[0], b_sr[0], and carry to the single FullAdder instance.
  - The adder's Sum bit shifts into the MSB of an internal result shift register (shift right). A and B also shift right.
  - carry ← adder Cout; counter increments.
  - On the edge where the counter reaches WIDTH-1, the completed result is written to Sum, the final carry to Cout, and the state moves to DONE.
- DONE: lasts exactly one cycle, then goes unconditionally to IDLE.
- Start is ignored in RUN and DONE. It is not queued.
- Exactly one FullAdder instance is used; no parallel adder is inferred.
- The counter is ceil(log2(WIDTH)) bits wide. The counter and shift registers are don't-care outside RUN.

## Timing
- Reset (Rst_n=0, asynchronous):
  - State → IDLE; Busy=0, Done=0, Sum=0, Cout=0.
  - Carry FF, counter, and shift registers are cleared.
  - Reset takes effect immediately in any state, including mid-RUN. The partial result is discarded and Sum/Cout read 0.
  - Release is synchronous to the next Clk edge. Start is first sampled on the first edge with Rst_n=1.
- Busy and Done are registered state decodes:
  - Busy=1 in RUN only.
  - Done=1 in DONE only.
- Latency: if Start is accepted at edge k, then:
  - Busy is high from after edge k until edge k+WIDTH.
  - Sum, Cout, and Done update at edge k+WIDTH.
  - Done falls at edge k+WIDTH+1.
- Throughput: the earliest next accept is edge k+WIDTH+2, so the period is WIDTH+2 cycles.
- Sum and Cout change only at completion edges or on reset.
- A, B, Cin, and Sub may change freely after the accepting edge.

## Configuration
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Sub=1 captured at accept makes B load as ~B and sets the carry FF to 1, ignoring Cin.
  - The result is A−B mod 2^WIDTH.
  - Cout=1 means no borrow (A≥B unsigned).
  - Sub=0 behaves as an add.
- Undefined:
  - The Sub port exists but is ignored; every operation is A+B+Cin.
  - No inversion logic is synthesized.

## Test plan (WIDTH=8)
- Reset, then A=0x5A, B=0x3C, Cin=0, Start pulse at edge k -> Busy high for 8 cycles; at edge k+8 Sum=0x96, Cout=0, Done=1 for exactly one cycle.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1. A=0xFF, B=0x00, Cin=1 -> Sum=0x00, Cout=1. A=0x00, B=0x00, Cin=1 -> Sum=0x01, Cout=0.
- Start held high continuously from edge k -> accepts at k, k+10, k+20. Operand changes during RUN do not affect the in-flight result. Sum holds between Done pulses.
- Rst_n asserted asynchronously mid-cycle when the counter equals 3 in RUN -> Busy, Done, Sum, and Cout go to 0 immediately without a clock edge. After release, a new op A=0x01, B=0x01 -> Sum=0x02.
- SERIAL_ADDER_SUB_EN defined: Sub=1, A=0x10, B=0x01 -> Sum=0x0F, Cout=1. Sub=1, A=0x00, B=0x01, Cin=0 -> Sum=0xFF, Cout=0.
- SERIAL_ADDER_SUB_EN undefined: Sub=1, A=0x10, B=0x01, Cin=0 -> Sum=0x11, Cout=0.
